// File: rtl/user_pkg.sv
// user_pkg: shared register offsets, engine state type and byte-mask helper for the user domain.
package user_pkg;
  localparam logic [11:0] SetbitaccDataOffset = 12'h000;
  localparam logic [11:0] AccOffset           = 12'h004;
  localparam logic [11:0] StatusOffset        = 12'h008;
  localparam logic [11:0] CountOffset         = 12'h00C;
  typedef enum logic {SbaIdle, SbaCount} setbitacc_state_e;
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction
endpackage

// File: rtl/setbitacc_popcnt.sv
// setbitacc_popcnt: combinational popcount of one engine slice.
module setbitacc_popcnt #(
  parameter int unsigned Width = 8,
  localparam int unsigned CntW = $clog2(Width + 1)
) (
  input  logic [Width-1:0] i_bits,
  output logic [CntW-1:0]  o_cnt
);
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < Width; i++) o_cnt = o_cnt + CntW'(i_bits[i]);
  end
endmodule

// File: rtl/user_setbitacc.sv
// user_setbitacc: OBI subordinate that popcounts written words bit-serially into a 32-bit accumulator.
module user_setbitacc
  import user_pkg::*;
#(
  parameter int unsigned BitsPerCycle = 8,
  parameter int unsigned IdWidth      = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [31:0]        wdata_i,
  input  logic [IdWidth-1:0] aid_i,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  output logic [IdWidth-1:0] rid_o,
  output logic               err_o,
  output logic               busy_o
);
  localparam int unsigned N    = 32 / BitsPerCycle;
  localparam int unsigned CntW = $clog2(BitsPerCycle + 1);
  setbitacc_state_e r_state;
  logic [31:0] r_acc, r_last, r_count, r_sr, r_rdata;
  logic [5:0] r_beat;
  logic r_ovf, r_rvalid, r_err;
  logic [IdWidth-1:0] r_rid;
  logic w_busy, w_gnt, w_data, w_acc, w_stat, w_cnt, w_hit, w_unused;
  logic [31:0] w_mask, w_masked, w_rdata;
  logic [CntW-1:0] w_pc;
  logic [32:0] w_sum;
  assign w_busy   = r_state == SbaCount;
  assign w_gnt    = req_i & ~w_busy & rst_ni;
  assign w_data   = addr_i[11:2] == SetbitaccDataOffset[11:2];
  assign w_acc    = addr_i[11:2] == AccOffset[11:2];
  assign w_stat   = addr_i[11:2] == StatusOffset[11:2];
  assign w_cnt    = addr_i[11:2] == CountOffset[11:2];
  assign w_hit    = w_data | w_acc | w_stat | w_cnt;
  assign w_unused = ^{addr_i[31:12], addr_i[1:0]};
  assign w_mask   = be_mask(be_i);
  assign w_masked = wdata_i & w_mask;
  assign w_sum    = {1'b0, r_acc} + 33'(w_pc);
  assign w_rdata  = w_data ? r_last : w_acc ? r_acc : w_stat ? {30'd0, r_ovf, w_busy} : w_cnt ? r_count : '0;
  setbitacc_popcnt #(.Width(BitsPerCycle)) u_popcnt (
    .i_bits(r_sr[BitsPerCycle-1:0]),
    .o_cnt (w_pc)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= SbaIdle;
      r_acc    <= '0;
      r_last   <= '0;
      r_count  <= '0;
      r_sr     <= '0;
      r_beat   <= '0;
      r_ovf    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rid    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_gnt;
      r_rid    <= w_gnt ? aid_i : '0;
      r_err    <= w_gnt & ~w_hit;
      r_rdata  <= (w_gnt & ~we_i) ? w_rdata : '0;
      if (w_busy) begin
        r_acc  <= w_sum[31:0];
        r_ovf  <= r_ovf | w_sum[32];
        r_sr   <= r_sr >> BitsPerCycle;
        r_beat <= r_beat + 6'd1;
        if (r_beat == 6'(N - 1)) r_state <= SbaIdle;
      end else if (w_gnt & we_i) begin
        if (w_data) begin
          r_sr    <= w_masked;
          r_last  <= w_masked;
          r_count <= r_count + 32'd1;
          r_beat  <= '0;
          r_state <= SbaCount;
        end
        if (w_acc) r_acc <= (r_acc & ~w_mask) | w_masked;
        if (w_stat & be_i[0] & wdata_i[1]) r_ovf <= 1'b0;
      end
    end
  end
  assign gnt_o    = w_gnt;
  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign rid_o    = r_rid;
  assign err_o    = r_err;
  assign busy_o   = w_busy;
endmodule

// File: tb/tb_user_setbitacc.sv
// tb_user_setbitacc: register-level model of the popcount accumulator checked every cycle, plus literal read-backs.
module tb_user_setbitacc;
  localparam int NB = 4;
  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, aid = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0] be = '0;
  logic gnt_o, rvalid_o, err_o, busy_o;
  logic [31:0] rdata_o;
  logic [0:0] rid_o;
  int checks = 0, errors = 0, cyc = 0;
  logic rst_prev = 1'b1;
  typedef struct {int cyc; logic [31:0] rdata; logic err; logic id;} rsp_t;
  rsp_t q[$];
  rsp_t e;
  logic eb;
  logic [31:0] m_acc = '0, m_count = '0, m_last = '0;
  logic m_ovf = 1'b0;
  int b_lo = 1, b_hi = 0;

  user_setbitacc #(.BitsPerCycle(8), .IdWidth(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_o), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .aid_i(aid), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .rid_o(rid_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_prev <= !rst_n;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, x, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_prev) begin
      chk("rst_rvalid", rvalid_o, 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_rid", rid_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_busy", busy_o, 0);
      if (!rst_n) chk("rst_gnt", gnt_o, 0);
    end else begin
      eb = (cyc >= b_lo) && (cyc <= b_hi);
      chk("busy", busy_o, eb);
      chk("gnt", gnt_o, req && !eb && rst_n);
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("rvalid", rvalid_o, 1);
        chk("rdata", rdata_o, e.rdata);
        chk("err", err_o, e.err);
        chk("rid", rid_o, e.id);
      end else chk("rvalid_idle", rvalid_o, 0);
    end
  end

  task automatic grant_model(input logic [31:0] a, input logic w, input logic [3:0] b,
                             input logic [31:0] d, input logic id);
    rsp_t r;
    logic [31:0] mk, m;
    logic [32:0] s;
    mk = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    m = d & mk;
    r.cyc = cyc + 1;
    r.id = id;
    r.err = 1'b0;
    r.rdata = '0;
    case (a[11:0] & 12'hFFC)
      12'h000: if (w) begin
        m_last = m;
        m_count = m_count + 1;
        s = {1'b0, m_acc} + 33'($countones(m));
        m_acc = s[31:0];
        m_ovf = m_ovf | s[32];
        b_lo = cyc + 1;
        b_hi = cyc + NB;
      end else r.rdata = m_last;
      12'h004: if (w) m_acc = (m_acc & ~mk) | m; else r.rdata = m_acc;
      12'h008: if (w) begin if (b[0] && d[1]) m_ovf = 1'b0; end else r.rdata = {30'd0, m_ovf, 1'b0};
      12'h00C: if (!w) r.rdata = m_count;
      default: r.err = 1'b1;
    endcase
    q.push_back(r);
  endtask

  task automatic xact(input logic [31:0] a, input logic w, input logic [3:0] b,
                      input logic [31:0] d, input logic id);
    int n;
    req = 1'b1; addr = a; we = w; be = b; wdata = d; aid = id;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (gnt_o) break;
    end
    if (n == 40) begin
      errors++;
      $display("FAIL gnt_timeout: got no grant expected grant for addr %h", a);
    end else grant_model(a, w, b, d, id);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic rd_lit(input logic [31:0] a, input logic [31:0] x, input logic xe, input logic id);
    xact(a, 1'b0, 4'hF, 32'h0, id);
    @(negedge clk);
    chk("lit_rdata", rdata_o, x);
    chk("lit_err", err_o, xe);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    m_acc = '0; m_count = '0; m_last = '0; m_ovf = 1'b0;
    if (b_hi > cyc) b_hi = cyc;
    while (q.size() > 0 && q[$].cyc > cyc) q.pop_back();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rd_lit(32'h2000_1004, 32'h0, 0, 0);
    rd_lit(32'h2000_100C, 32'h0, 0, 0);
    rd_lit(32'h2000_1008, 32'h0, 0, 0);
    xact(32'h2000_1000, 1, 4'hF, 32'hFFFF_FFFF, 0);
    rd_lit(32'h2000_1004, 32'd32, 0, 1);
    rd_lit(32'h2000_100C, 32'd1, 0, 0);
    rd_lit(32'h2000_1000, 32'hFFFF_FFFF, 0, 0);
    xact(32'h2000_1000, 1, 4'h3, 32'hA5A5_A5A5, 1);
    rd_lit(32'h2000_1004, 32'd40, 0, 0);
    rd_lit(32'h2000_1000, 32'h0000_A5A5, 0, 0);
    xact(32'h2000_1004, 1, 4'hF, 32'hFFFF_FFF0, 0);
    xact(32'h2000_1000, 1, 4'hF, 32'h0000_00FF, 0);
    rd_lit(32'h2000_1004, 32'hFFFF_FFF8, 0, 0);
    rd_lit(32'h2000_1008, 32'h0, 0, 0);
    xact(32'h2000_1000, 1, 4'hF, 32'h0000_FFFF, 1);
    rd_lit(32'h2000_1004, 32'h0000_0008, 0, 0);
    rd_lit(32'h2000_1008, 32'h2, 0, 0);
    xact(32'h2000_1008, 1, 4'h1, 32'h2, 0);
    rd_lit(32'h2000_1008, 32'h0, 0, 0);
    rd_lit(32'h2000_1010, 32'h0, 1, 1);
    xact(32'h2000_1014, 1, 4'hF, 32'h1234_5678, 1);
    xact(32'h2000_100C, 1, 4'hF, 32'h55, 0);
    xact(32'h2000_1004, 0, 4'hF, 32'h0, 1);
    xact(32'h2000_1000, 1, 4'h0, 32'hFFFF_FFFF, 0);
    rd_lit(32'h2000_100C, 32'd5, 0, 0);
    rd_lit(32'h2000_1004, 32'h0000_0008, 0, 0);
    xact(32'h2000_1000, 1, 4'hF, 32'hFFFF_FFFF, 0);
    do_reset();
    rd_lit(32'h2000_1004, 32'h0, 0, 0);
    rd_lit(32'h2000_100C, 32'h0, 0, 0);
    rd_lit(32'h2000_1008, 32'h0, 0, 0);
    repeat (3) @(posedge clk);
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no end expected finish");
    $fatal(1, "timeout");
  end
endmodule
